// File: rtl/shuffle_index_picker.sv
// Compacts a candidate bitmap into an index table, then issues each index once in random order; optional macro PICK_MOD_EN selects rand%count picking.
// Latency: start edge N -> out_valid after edge N+BS/SCAN_W+1; one pick per 2 cycles. Backpressure: pick held stable while out_ready low.
module shuffle_index_picker #(
    parameter int BS     = 16,
    parameter int SCAN_W = 4,
    parameter int RAND_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [BS-1:0]              cand_list,
    input  logic [RAND_W-1:0]          rand_num,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(BS)-1:0]      out_index,
    output logic                       out_last,
    output logic [$clog2(BS+1)-1:0]    remaining,
    output logic                       busy,
    output logic                       empty_err
);
    localparam int IDX_W = $clog2(BS);
    localparam int CNT_W = $clog2(BS + 1);
    localparam int NSCAN = BS / SCAN_W;
    localparam int PTR_W = (NSCAN > 1) ? $clog2(NSCAN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CALC, S_PRESENT} state_t;

    state_t             state_q, state_d;
    logic [BS-1:0]      snap_q, snap_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   map_q [BS];
    logic [IDX_W-1:0]   map_d [BS];
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   pick_sel;
    logic [SCAN_W-1:0]  seg;
    logic [CNT_W-1:0]   wr;

`ifdef PICK_MOD_EN
    logic [RAND_W-1:0]  mod_res;
    always_comb begin
        mod_res = '0;
        if (count_q != '0)
            mod_res = rand_num % RAND_W'(count_q);
    end
    assign pick_sel = IDX_W'(mod_res);
`else
    // Scaling a 16-bit fraction by count keeps sel < count without a divider.
    logic [15+CNT_W:0]  prod;
    logic               unused_rand_hi;
    assign prod           = (16 + CNT_W)'(rand_num[15:0]) * (16 + CNT_W)'(count_q);
    assign pick_sel       = IDX_W'(prod >> 16);
    assign unused_rand_hi = ^rand_num[RAND_W-1:16];
`endif

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        map_d   = map_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        last_d  = last_q;
        err_d   = 1'b0;
        seg     = snap_q[int'(ptr_q)*SCAN_W +: SCAN_W];
        wr      = count_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d  = cand_list;
                    count_d = '0;
                    ptr_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                for (int j = 0; j < SCAN_W; j++) begin
                    if (seg[j]) begin
                        if (wr < CNT_W'(BS))
                            map_d[wr[IDX_W-1:0]] = IDX_W'(int'(ptr_q)*SCAN_W + j);
                        wr = wr + CNT_W'(1);
                    end
                end
                count_d = wr;
                ptr_d   = ptr_q + PTR_W'(1);
                if (ptr_q == PTR_W'(NSCAN - 1)) begin
                    if (wr == '0) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                sel_d   = pick_sel;
                idx_d   = map_q[pick_sel];
                last_d  = (count_q == CNT_W'(1));
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (out_ready) begin
                    // Swap-remove keeps the live entries packed in map[0..count-1].
                    map_d[sel_q] = map_q[IDX_W'(count_q - CNT_W'(1))];
                    count_d      = count_q - CNT_W'(1);
                    last_d       = 1'b0;
                    state_d      = (count_q == CNT_W'(1)) ? S_IDLE : S_CALC;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            count_d = '0;
            last_d  = 1'b0;
            err_d   = 1'b0;
        end
        valid_d = (state_d == S_PRESENT);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < BS; i++) map_q[i] <= '0;
            sel_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            map_q   <= map_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_index = idx_q;
    assign out_last  = last_q;
    assign remaining = count_q;
    assign busy      = busy_q;
    assign empty_err = err_q;
endmodule

// File: tb/tb_shuffle_index_picker.sv
// Directed bench for shuffle_index_picker (BS=16, SCAN_W=4); expectations follow the PICK_MOD_EN build selection.
module tb_shuffle_index_picker;
    localparam int BS = 16;
    localparam int SCAN_W = 4;
    localparam int RAND_W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, out_ready;
    logic [15:0] cand_list;
    logic [31:0] rand_num;
    logic        out_valid, out_last, busy, empty_err;
    logic [3:0]  out_index;
    logic [4:0]  remaining;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shuffle_index_picker #(.BS(BS), .SCAN_W(SCAN_W), .RAND_W(RAND_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cand_list(cand_list), .rand_num(rand_num),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_last(out_last), .remaining(remaining), .busy(busy), .empty_err(empty_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] cand);
        cand_list = cand;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                return;
            end
            step();
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        cand_list = '0; rand_num = '0;
        step(); step();
        checks++;
        if ({out_valid, out_last, busy, empty_err} !== 4'b0 || remaining !== 5'd0 || out_index !== 4'd0) begin
            failures++;
            $display("FAIL reset_state: valid=%b last=%b busy=%b err=%b rem=%0d idx=%0d, required all 0",
                     out_valid, out_last, busy, empty_err, remaining, out_index);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_ordered();
        logic [3:0] exp_idx [4];
        bit ok;
        exp_idx[0] = 4'd0; exp_idx[1] = 4'd15; exp_idx[2] = 4'd10; exp_idx[3] = 4'd5;
        rand_num = 32'd0; out_ready = 1'b1;
        do_start(16'h8421);
        repeat (4) step();
        checks++;
        if (out_valid !== 1'b0 || remaining !== 5'd4) begin
            failures++;
            $display("FAIL ordered_scan: valid=%b rem=%0d, required valid=0 rem=4", out_valid, remaining);
        end
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL ordered_latency: valid=%b, required 1 after start+5 edges", out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            wait_valid(4, ok);
            checks++;
            if (!ok || out_index !== exp_idx[k] || out_last !== (k == 3) || remaining !== 5'(4 - k)) begin
                failures++;
                $display("FAIL ordered_pick%0d: valid=%b idx=%0d last=%b rem=%0d, required idx=%0d last=%b rem=%0d",
                         k, out_valid, out_index, out_last, remaining, exp_idx[k], (k == 3), 4 - k);
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || remaining !== 5'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ordered_done: busy=%b rem=%0d valid=%b, required 0 0 0", busy, remaining, out_valid);
        end
    endtask

    task automatic test_full();
        logic [15:0] seen;
        bit ok;
        seen = '0;
        out_ready = 1'b1;
        rand_num = $urandom;
        do_start(16'hFFFF);
        repeat (4) begin rand_num = $urandom; step(); end
        checks++;
        if (remaining !== 5'd16) begin
            failures++;
            $display("FAIL full_count: rem=%0d, required 16", remaining);
        end
        for (int k = 0; k < 16; k++) begin
            wait_valid(4, ok);
            checks++;
            if (!ok || seen[out_index] !== 1'b0 || out_last !== (k == 15)) begin
                failures++;
                $display("FAIL full_pick%0d: valid=%b idx=%0d dup=%b last=%b, required valid=1 fresh last=%b",
                         k, out_valid, out_index, seen[out_index], out_last, (k == 15));
            end
            seen[out_index] = 1'b1;
            rand_num = $urandom;
            step();
        end
        checks++;
        if (seen !== 16'hFFFF || busy !== 1'b0) begin
            failures++;
            $display("FAIL full_cover: seen=%h busy=%b, required ffff 0", seen, busy);
        end
    endtask

    task automatic test_empty();
        int pulses = 0;
        int at = -1;
        bit saw_valid = 1'b0;
        do_start(16'h0000);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (empty_err) begin pulses++; at = i; end
            if (out_valid) saw_valid = 1'b1;
        end
        checks++;
        if (pulses != 1 || at != 4 || saw_valid || busy !== 1'b0) begin
            failures++;
            $display("FAIL empty: pulses=%0d at_edge=%0d valid_seen=%b busy=%b, required 1 4 0 0",
                     pulses, at, saw_valid, busy);
        end
    endtask

    task automatic test_hold();
        logic [3:0] exp;
        bit stable = 1'b1;
`ifdef PICK_MOD_EN
        exp = 4'd4;
`else
        exp = 4'd7;
`endif
        out_ready = 1'b0;
        rand_num = 32'h0000_C000;
        do_start(16'h00F0);
        repeat (5) step();
        checks++;
        if (out_valid !== 1'b1 || out_index !== exp) begin
            failures++;
            $display("FAIL hold_first: valid=%b idx=%0d, required 1 %0d", out_valid, out_index, exp);
        end
        for (int i = 0; i < 5; i++) begin
            rand_num = $urandom;
            step();
            if (out_valid !== 1'b1 || out_index !== exp || out_last !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL hold_stable: valid=%b idx=%0d last=%b, required 1 %0d 0", out_valid, out_index, out_last, exp);
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || remaining !== 5'd3) begin
            failures++;
            $display("FAIL hold_accept: valid=%b rem=%0d, required 0 3", out_valid, remaining);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        out_ready = 1'b0;
        rand_num = 32'd0;
        do_start(16'h0007);
        step();
        cand_list = 16'hFFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        checks++;
        if (out_valid !== 1'b1 || remaining !== 5'd3) begin
            failures++;
            $display("FAIL abort_ignore_start: valid=%b rem=%0d, required 1 3", out_valid, remaining);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || remaining !== 5'd0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL abort_clear: valid=%b busy=%b rem=%0d last=%b, required 0 0 0 0",
                     out_valid, busy, remaining, out_last);
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        out_ready = 1'b0;
        rand_num = 32'h0000_C000;
        do_start(16'h00F0);
        wait_valid(8, ok);
        rst = 1'b1;
        #2;
        checks++;
        if (!ok || out_valid !== 1'b0 || busy !== 1'b0 || remaining !== 5'd0 || out_index !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid: reached=%b valid=%b busy=%b rem=%0d idx=%0d, required 1 0 0 0 0",
                     ok, out_valid, busy, remaining, out_index);
        end
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_idle: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_pick_rule();
        logic [3:0] exp0, exp1;
        bit ok;
`ifdef PICK_MOD_EN
        exp0 = 4'd6; exp1 = 4'd4;
`else
        exp0 = 4'd4; exp1 = 4'd7;
`endif
        out_ready = 1'b1;
        rand_num = 32'd6;
        do_start(16'h00F0);
        wait_valid(8, ok);
        checks++;
        if (!ok || out_index !== exp0) begin
            failures++;
            $display("FAIL pick_rule0: valid=%b idx=%0d, required 1 %0d", out_valid, out_index, exp0);
        end
        step();
        wait_valid(4, ok);
        checks++;
        if (!ok || out_index !== exp1 || remaining !== 5'd3) begin
            failures++;
            $display("FAIL pick_rule1: valid=%b idx=%0d rem=%0d, required 1 %0d 3", out_valid, out_index, remaining, exp1);
        end
        repeat (8) step();
        checks++;
        if (busy !== 1'b0 || remaining !== 5'd0) begin
            failures++;
            $display("FAIL pick_drain: busy=%b rem=%0d, required 0 0", busy, remaining);
        end
    endtask

    initial begin
        test_reset();
        test_ordered();
        test_full();
        test_empty();
        test_hold();
        test_abort();
        test_rst_mid();
        test_pick_rule();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
